// File: rtl/div_scheduler_pkg.sv
// Shared types for the divider scheduler: response status codes and FSM states.
// Pure declarations, no logic.
package div_scheduler_pkg;

    typedef enum logic [1:0] {
        DIV_OK      = 2'd0,
        DIV_DIVZ    = 2'd1,
        DIV_TIMEOUT = 2'd2
    } div_status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_sched_state_t;

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Round-robin picker: first set req after ptr, with wrap; purely combinational.
// Zero latency, no backpressure; the caller decides when a grant is consumed.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] sel;

    // ptr < N and k <= N, so ptr+k stays below 2N and one subtraction wraps it
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            sel = sum[IW-1:0];
            if (!any && req[sel]) begin
                any        = 1'b1;
                idx        = sel;
                grant[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one divider between NREQ requesters; rsp at accept+2+D, bypass at accept+1.
// One job in flight: req_ready stays low until the response handshake completes.
module div_scheduler
    import div_scheduler_pkg::*;
#(
    parameter int  BITS    = 16,
    parameter int  NREQ    = 4,
    parameter int  TIMEOUT = 64,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_dividend,
    input  logic [NREQ*BITS-1:0] req_divisor,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_quotient,
    output logic [BITS-1:0]      rsp_remainder,
    output div_status_t          rsp_status,
    output logic                 div_start,
    output logic [BITS-1:0]      div_dividend,
    output logic [BITS-1:0]      div_divisor,
    output logic                 div_abort,
    input  logic                 div_done,
    input  logic [BITS-1:0]      div_quotient,
    input  logic [BITS-1:0]      div_remainder
);

    localparam int TW = $clog2(TIMEOUT);

    div_sched_state_t state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [TW-1:0]    timer;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic [BITS-1:0]  sel_dividend;
    logic [BITS-1:0]  sel_divisor;
    logic             sel_divz;
    logic             sel_zero;
    logic             timeout_hit;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_dividend = req_dividend[gnt_idx*BITS +: BITS];
    assign sel_divisor  = req_divisor[gnt_idx*BITS +: BITS];
    assign sel_divz     = (sel_divisor == '0);
    assign sel_zero     = (sel_dividend == '0);
    assign timeout_hit  = (timer == TW'(TIMEOUT - 1));

    assign req_ready = (state_q == IDLE) ? gnt : '0;
    assign rsp_valid = (state_q == RESP);
    // A done arriving on the last timer cycle wins, so no abort is raised then
    assign div_abort = (state_q == WAIT) && !div_done && timeout_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = (sel_divz || sel_zero) ? RESP : ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (div_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr        <= IDW'(NREQ - 1);
            timer         <= '0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_status    <= DIV_OK;
        end else begin
            state_q   <= state_d;
            div_start <= (state_d == ISSUE);
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        rr_ptr       <= gnt_idx;
                        rsp_id       <= gnt_idx;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        if (sel_divz) begin
                            rsp_quotient  <= '1;
                            rsp_remainder <= sel_dividend;
                            rsp_status    <= DIV_DIVZ;
                        end else if (sel_zero) begin
                            rsp_quotient  <= '0;
                            rsp_remainder <= '0;
                            rsp_status    <= DIV_OK;
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (div_done) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_status    <= DIV_OK;
                    end else if (timeout_hit) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_status    <= DIV_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural divider stand-in.
module tb_div_scheduler;
    import div_scheduler_pkg::*;

    localparam int BITS    = 16;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_dividend = '0;
    logic [NREQ*BITS-1:0] req_divisor = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [IDW-1:0]       rsp_id;
    logic [BITS-1:0]      rsp_quotient;
    logic [BITS-1:0]      rsp_remainder;
    div_status_t          rsp_status;
    logic                 div_start;
    logic [BITS-1:0]      div_dividend;
    logic [BITS-1:0]      div_divisor;
    logic                 div_abort;
    logic                 div_done;
    logic [BITS-1:0]      div_quotient;
    logic [BITS-1:0]      div_remainder;

    always #5 clk = ~clk;

    div_scheduler #(.BITS(BITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_status    (rsp_status),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_abort     (div_abort),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // Divider stand-in: reset by reset|abort, can be told to hang forever
    int              dv_lat  = 3;
    bit              dv_hang = 1'b0;
    bit              dv_spur = 1'b0;
    logic            dv_rst, dv_busy, dv_done;
    int              dv_cnt;
    logic [BITS-1:0] dv_q, dv_r;

    assign dv_rst        = reset | div_abort;
    assign div_done      = dv_done | dv_spur;
    assign div_quotient  = dv_q;
    assign div_remainder = dv_r;

    always @(posedge clk or posedge dv_rst) begin
        if (dv_rst) begin
            dv_busy <= 1'b0;
            dv_done <= 1'b0;
            dv_cnt  <= 0;
            dv_q    <= '0;
            dv_r    <= '0;
        end else begin
            dv_done <= 1'b0;
            if (div_start) begin
                dv_busy <= 1'b1;
                dv_cnt  <= dv_lat;
                dv_q    <= div_dividend / div_divisor;
                dv_r    <= div_dividend % div_divisor;
            end else if (dv_busy && !dv_hang) begin
                if (dv_cnt <= 1) begin
                    dv_busy <= 1'b0;
                    dv_done <= 1'b1;
                end
                dv_cnt <= dv_cnt - 1;
            end
        end
    end

    // Cycle stamps of divider-side pulses
    int cyc, n_start, n_abort, start_cyc, abort_cyc, done_cyc;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (div_abort) begin
            n_abort   <= n_abort + 1;
            abort_cyc <= cyc;
        end
        if (div_done) done_cyc <= cyc;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_rsp(input string tag, input int id, input int q, input int r,
                              input div_status_t st);
        chk({tag, "_id"}, 32'(rsp_id), id);
        chk({tag, "_q"}, 32'(rsp_quotient), q);
        chk({tag, "_r"}, 32'(rsp_remainder), r);
        chk({tag, "_st"}, 32'(rsp_status), 32'(st));
    endtask

    // Present a request, wait for its accept, drop valid after the accepting edge
    task automatic issue(input int id, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         output int acc);
        int n = 0;
        req_dividend[id*BITS +: BITS] = a;
        req_divisor[id*BITS +: BITS]  = b;
        req_valid[id] = 1'b1;
        #1;
        while (!req_ready[id] && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("accept", 32'(req_ready[id]), 1);
        acc = cyc;
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int t);
        int n = 0;
        #1;
        while (!rsp_valid && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("rsp_seen", 32'(rsp_valid), 1);
        t = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ta, tr, s0, a0, g, n;
        logic stable, busy_rdy, seen;

        @(negedge clk); #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_div_abort", 32'(div_abort), 0);
        chk("rst_rsp_q", 32'(rsp_quotient), 0);
        chk("rst_div_dividend", 32'(div_dividend), 0);
        reset = 1'b0;
        @(negedge clk);

        // 100/7 through the divider
        s0 = n_start;
        issue(0, 16'd100, 16'd7, ta);
        wait_rsp(tr);
        expect_rsp("t1", 0, 14, 2, DIV_OK);
        chk("t1_start_cyc", start_cyc, ta + 1);
        chk("t1_rsp_cyc", tr, done_cyc + 1);
        @(negedge clk); @(negedge clk);
        chk("t1_nstart", n_start - s0, 1);

        // 55/0 bypass, then a spurious done while idle
        s0 = n_start;
        issue(2, 16'd55, 16'd0, ta);
        wait_rsp(tr);
        expect_rsp("t2", 2, 16'hFFFF, 55, DIV_DIVZ);
        chk("t2_lat", tr - ta, 1);
        @(negedge clk);
        dv_spur = 1'b1;
        @(negedge clk);
        dv_spur = 1'b0;
        #1;
        chk("t2_spur_rsp", 32'(rsp_valid), 0);
        chk("t2_nstart", n_start - s0, 0);

        // req0 and req1 held continuously: strict alternation 0,1,0,1...
        req_dividend[0*BITS +: BITS] = 16'd20;
        req_divisor[0*BITS +: BITS]  = 16'd3;
        req_dividend[1*BITS +: BITS] = 16'd7;
        req_divisor[1*BITS +: BITS]  = 16'd7;
        req_valid = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 300) begin
                @(negedge clk); #1; n++;
            end
            g = (req_ready == 4'b0001) ? 0 : (req_ready == 4'b0010) ? 1 : 9;
            chk("rr_grant", g, k % 2);
            if (k == 7) begin
                @(negedge clk);
                req_valid = '0;
            end
            wait_rsp(tr);
            chk("rr_id", 32'(rsp_id), k % 2);
            chk("rr_q", 32'(rsp_quotient), (k % 2 == 1) ? 1 : 6);
            @(negedge clk);
        end

        // Hung divider: abort 64 cycles after start, then a normal job
        dv_hang = 1'b1;
        a0 = n_abort;
        issue(3, 16'd500, 16'd3, ta);
        wait_rsp(tr);
        expect_rsp("t4", 3, 0, 0, DIV_TIMEOUT);
        chk("t4_abort_dist", abort_cyc - start_cyc, 64);
        chk("t4_nabort", n_abort - a0, 1);
        chk("t4_rsp_cyc", tr, abort_cyc + 1);
        @(negedge clk);
        dv_hang = 1'b0;
        issue(1, 16'd9, 16'd4, ta);
        wait_rsp(tr);
        expect_rsp("t4b", 1, 2, 1, DIV_OK);
        @(negedge clk);

        // Response stalled 10 cycles with req1 pending
        rsp_ready = 1'b0;
        issue(0, 16'd0, 16'd5, ta);
        req_dividend[1*BITS +: BITS] = 16'd9;
        req_divisor[1*BITS +: BITS]  = 16'd2;
        req_valid[1] = 1'b1;
        wait_rsp(tr);
        chk("t5_lat", tr - ta, 1);
        stable   = 1'b1;
        busy_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            stable = stable && rsp_valid && rsp_id == 0 && rsp_quotient == 0 &&
                     rsp_remainder == 0 && rsp_status == DIV_OK;
            busy_rdy = busy_rdy || (req_ready != '0);
            @(negedge clk); #1;
        end
        chk("t5_stable", 32'(stable), 1);
        chk("t5_no_ready", 32'(busy_rdy), 0);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("t5_ready_after", 32'(req_ready), 32'h2);
        chk("t5_vld_drop", 32'(rsp_valid), 0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(tr);
        expect_rsp("t5b", 1, 4, 1, DIV_OK);
        @(negedge clk);

        // Asynchronous reset in WAIT discards the job
        dv_lat = 20;
        issue(2, 16'd1000, 16'd10, ta);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_rsp_valid", 32'(rsp_valid), 0);
        chk("t6_div_start", 32'(div_start), 0);
        chk("t6_div_abort", 32'(div_abort), 0);
        chk("t6_rsp_id", 32'(rsp_id), 0);
        chk("t6_div_dividend", 32'(div_dividend), 0);
        chk("t6_div_divisor", 32'(div_divisor), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            seen = seen || rsp_valid;
        end
        chk("t6_no_rsp", 32'(seen), 0);
        issue(2, 16'd1000, 16'd10, ta);
        wait_rsp(tr);
        expect_rsp("t6b", 2, 100, 0, DIV_OK);
        chk("t6b_rsp_cyc", tr, done_cyc + 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
